// File: rtl/add_sub_sched.sv
// Round-robin arbiter in front of one 4-bit add/sub slice, sequenced LS nibble first.
// Result after NIBBLES cycles; response held until rsp_ready, requests stalled meanwhile.
module add_sub_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic                   req0_m,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic                   req1_m,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [4*NIBBLES-1:0]   rsp_s,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic                   busy
);
    localparam int W = 4 * NIBBLES;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [2:0]   k_q, k_d;
    logic         carry_q, carry_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] bx_q, bx_d;
    logic [W-1:0] s_q, s_d;
    logic         id_q, id_d;
    logic         cout_q, cout_d;
    logic         ovf_q, ovf_d;

    logic         grant1;
    logic         acc_m;
    logic [3:0]   nib_a, nib_b;
    logic [4:0]   sum;

    // Requester 1 wins only when alone or when requester 0 had the last turn.
    assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
    assign req0_ready = (state_q == IDLE) && req0_valid && !grant1;
    assign req1_ready = (state_q == IDLE) && grant1;

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_s     = s_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k_q == 3'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = bx_q[4*i +: 4];
            end
        end
        sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, carry_q};
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        k_d          = k_q;
        carry_d      = carry_q;
        a_d          = a_q;
        bx_d         = bx_q;
        s_d          = s_q;
        id_d         = id_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        acc_m        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    acc_m        = req1_ready ? req1_m : req0_m;
                    a_d          = req1_ready ? req1_a : req0_a;
                    bx_d         = (req1_ready ? req1_b : req0_b) ^ {W{acc_m}};
                    carry_d      = acc_m;
                    id_d         = req1_ready;
                    last_grant_d = req1_ready;
                    k_d          = '0;
                    state_d      = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (k_q == 3'(i)) s_d[4*i +: 4] = sum[3:0];
                end
                carry_d = sum[4];
                k_d     = k_q + 3'd1;
                if (k_q == 3'(NIBBLES - 1)) begin
                    cout_d  = sum[4];
                    ovf_d   = (a_q[W-1] == bx_q[W-1]) && (sum[3] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            k_q          <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            bx_q         <= '0;
            s_q          <= '0;
            id_q         <= 1'b0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            k_q          <= k_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            bx_q         <= bx_d;
            s_q          <= s_d;
            id_q         <= id_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
        end
    end
endmodule

// File: tb/tb_add_sub_sched.sv
// Bench for add_sub_sched: cycle model compared every negedge plus directed literal vectors.
module tb_add_sub_sched;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req0_m = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0;
    logic         req1_valid = 1'b0, req1_m = 1'b0;
    logic [W-1:0] req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_s;

    int checks = 0;
    int errors = 0;

    add_sub_sched #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference arithmetic from plain integer semantics.
    function automatic logic [17:0] ref_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, r;
        logic [W-1:0] s;
        logic c, o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = m ? sa - sb : sa + sb;
        o  = (r > 32767) || (r < -32768);
        s  = m ? a - b : a + b;
        c  = m ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        return {s, c, o};
    endfunction

    // Model state: 0 idle, 1 calculating, 2 holding response.
    int           m_st = 0;
    int           m_cnt = 0;
    logic         m_last = 1'b1;
    logic         m_id = 1'b0;
    logic [17:0]  m_res = '0;
    logic         e_r0, e_r1;
    logic         rsp_ids[$];

    always @(negedge clk) begin
        if (rst) begin
            m_st = 0; m_cnt = 0; m_last = 1'b1;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_s", 32'(rsp_s), 32'd0);
            chk("rst_flags", 32'({rsp_id, rsp_cout, rsp_ovf}), 32'd0);
        end else begin
            e_r0 = (m_st == 0) && req0_valid && (!req1_valid || m_last);
            e_r1 = (m_st == 0) && req1_valid && (!req0_valid || !m_last);
            chk("mdl_req0_ready", 32'(req0_ready), 32'(e_r0));
            chk("mdl_req1_ready", 32'(req1_ready), 32'(e_r1));
            chk("rdy_exclusive", 32'(req0_ready && req1_ready), 32'd0);
            chk("mdl_rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
            chk("mdl_busy", 32'(busy), 32'(m_st != 0));
            if (m_st == 2) begin
                chk("mdl_rsp_id", 32'(rsp_id), 32'(m_id));
                chk("mdl_rsp", 32'({rsp_s, rsp_cout, rsp_ovf}), 32'(m_res));
            end
            if (m_st == 0 && (e_r0 || e_r1)) begin
                m_id   = e_r1;
                m_last = e_r1;
                m_res  = e_r1 ? ref_op(req1_m, req1_a, req1_b) : ref_op(req0_m, req0_a, req0_b);
                m_st   = 1;
                m_cnt  = 0;
            end else if (m_st == 1) begin
                m_cnt++;
                if (m_cnt == N) m_st = 2;
            end else if (m_st == 2 && rsp_ready) begin
                rsp_ids.push_back(rsp_id);
                m_st = 0;
            end
        end
    end

    task automatic do_op(input logic id, input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
        int n, lat, bc;
        logic [W-1:0] cs;
        logic cc, co, ci;
        cs = '0; cc = 1'b0; co = 1'b0; ci = 1'b0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_m = m; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_m = m; req0_a = a; req0_b = b; end
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 16'($urandom); req0_b = 16'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
        lat = -1; bc = 0;
        while (busy && bc < 50) begin
            if (rsp_valid && lat < 0) begin
                lat = bc; cs = rsp_s; cc = rsp_cout; co = rsp_ovf; ci = rsp_id;
            end
            bc++;
            @(posedge clk); #1;
        end
        chk({nm, "_s"}, 32'(cs), 32'(es));
        chk({nm, "_cout"}, 32'(cc), 32'(ec));
        chk({nm, "_ovf"}, 32'(co), 32'(eo));
        chk({nm, "_id"}, 32'(ci), 32'(id));
        chk({nm, "_latency"}, lat, 32'd4);
        chk({nm, "_busy_cycles"}, bc, 32'd5);
    endtask

    initial begin
        int n;
        logic [W-1:0] hs;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        do_op(0, 0, 16'h1234, 16'h0FCD, 16'h2201, 0, 0, "add");
        do_op(1, 1, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, "sub_borrow");
        do_op(0, 1, 16'h0007, 16'h0005, 16'h0002, 1, 0, "sub_pos");
        do_op(1, 1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, "sub_ovf");
        do_op(0, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, "add_ovf");
        do_op(1, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, "add_carry");

        // Fairness from reset with both requesters always pending.
        @(posedge clk); #1 rst = 1;
        @(posedge clk); @(posedge clk); #1 rst = 0;
        rsp_ids.delete();
        req0_valid = 1; req0_m = 0; req0_a = 16'h1111; req0_b = 16'h0101;
        req1_valid = 1; req1_m = 1; req1_a = 16'h5000; req1_b = 16'h0123;
        n = 0;
        while (rsp_ids.size() < 6 && n < 200) begin @(posedge clk); #1; n++; end
        req0_valid = 0; req1_valid = 0;
        chk("fair_count", 32'(rsp_ids.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < rsp_ids.size(); i++) chk("fair_id", 32'(rsp_ids[i]), 32'(i % 2));
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end

        // Backpressure hold in DONE.
        rsp_ready = 0;
        req0_valid = 1; req0_m = 0; req0_a = 16'h00FF; req0_b = 16'h0001;
        n = 0;
        while (!req0_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req0_valid = 0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_valid_seen", 32'(rsp_valid), 32'd1);
        hs = rsp_s;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_s", 32'(rsp_s), 32'h0100);
            chk("bp_hold_busy", 32'(busy), 32'd1);
            chk("bp_hold_readies", 32'({req0_ready, req1_ready}), 32'd0);
        end
        chk("bp_stable_s", 32'(rsp_s), 32'(hs));
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);

        // Reset in the middle of a calculation.
        req1_valid = 1; req1_m = 0; req1_a = 16'h1111; req1_b = 16'h2222;
        n = 0;
        while (!req1_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1 req1_valid = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("mid_s_partial", 32'(rsp_s[7:0]), 32'h33);
        rst = 1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_s", 32'(rsp_s), 32'd0);
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
        end
        req0_valid = 1; req0_m = 1; req0_a = 16'h0010; req0_b = 16'h0001;
        req1_valid = 1; req1_m = 0; req1_a = 16'h0002; req1_b = 16'h0003;
        #1;
        chk("post_abort_grant", 32'({req0_ready, req1_ready}), 32'b10);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        n = 0;
        while (busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("final_idle", 32'(busy), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/add_sub_sched.md
# add_sub_sched

Round-robin scheduler and nibble-serial sequencer that shares one 4-bit add/subtract slice between two requesters. Each requester submits a wide add or subtract over a valid/ready handshake. The block computes the result one nibble per cycle, least-significant first, chaining the carry in an internal register. It returns the sum, carry and signed overflow, tagged with the requester id, over a valid/ready response channel. It sits between the two operand sources and the result consumer in the arithmetic datapath.

## Interface
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES; legal range 1..8.

- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_m  in  1  0 = add, 1 = subtract (a - b)
- req0_a, req0_b  in  W  operands
- req1_valid, req1_ready, req1_m, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that owns the result
- rsp_s  out  W  result, two's complement
- rsp_cout  out  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
- rsp_ovf  out  1  signed overflow
- busy  out  1  high in CALC or DONE

## Operation
- States:
  - IDLE: accepts one request.
  - CALC: sequences nibbles; counter k runs 0..NIBBLES-1.
  - DONE: holds the response.
- Arbitration in IDLE (combinational):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - reqX_ready = (state==IDLE) && grant==X. Ready is never high for both requesters, and never high outside IDLE.
- Acceptance (valid && ready on an edge):
  - Latch m, a, b^{W{m}} and id.
  - carry <= m.
  - last_grant <= id.
  - k <= 0.
  - Go to CALC.
- CALC, each cycle:
  - {c, n} = a[4k+3:4k] + bx[4k+3:4k] + carry.
  - Result nibble k <= n; carry <= c.
  - On k == NIBBLES-1:
    - rsp_cout <= c.
    - rsp_ovf <= (a[W-1] == bx[W-1]) && (n[3] != a[W-1]).
    - Go to DONE.
- DONE:
  - rsp_valid = 1.
  - rsp_id, rsp_s, rsp_cout and rsp_ovf are held stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE.
- Arithmetic is modulo 2^W. No saturation.
- Requester inputs are ignored outside the acceptance edge. They may change freely after acceptance.
- Reset mid-operation: the operation is aborted silently. No response is produced, and the requester must resubmit.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first contention).
  - rsp_valid = 0, rsp_id = 0, rsp_s = 0, rsp_cout = 0, rsp_ovf = 0, busy = 0.
  - req0_ready and req1_ready follow the combinational rule, so they are 0 unless the matching valid is high.
- Latency:
  - Acceptance on edge E.
  - Nibbles are computed on edges E+1..E+NIBBLES.
  - rsp_valid rises after edge E+NIBBLES.
- Throughput:
  - Earliest re-acceptance is the cycle after the response handshake.
  - With rsp_ready held high, the minimum period is NIBBLES+2 cycles per operation.
- Response rules:
  - rsp_valid never depends combinationally on rsp_ready.
  - reqX_ready depends combinationally on the valids and the state only.

## Test plan
- Add (NIBBLES=4): req0 m=0, a=0x1234, b=0x0FCD -> rsp_s=0x2201, cout=0, ovf=0, id=0; rsp_valid rises exactly 4 cycles after acceptance; busy high for 5 cycles with rsp_ready=1.
- Subtract:
  - m=1, a=0x0005, b=0x0007 -> rsp_s=0xFFFE, cout=0, ovf=0.
  - m=1, a=0x0007, b=0x0005 -> rsp_s=0x0002, cout=1, ovf=0.
  - m=1, a=0x8000, b=0x0001 -> rsp_s=0x7FFF, cout=1, ovf=1.
- Add overflow and carry:
  - m=0, 0x7FFF + 0x0001 -> 0x8000, cout=0, ovf=1.
  - m=0, 0xFFFF + 0x0001 -> 0x0000, cout=1, ovf=0.
- Fairness: both valids held high from reset with distinct operands -> grants 0,1,0,1,...; rsp_id alternates; no requester is starved; the two readies are never high together.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and all rsp fields stable, both readies 0, busy=1; completes on the first cycle rsp_ready=1.
- Reset mid-CALC: assert rst after 2 nibbles -> all outputs at reset values immediately without a clock edge; no response appears after release; next contention grants requester 0.
